fft_reorder_buf: RTL and testbench
==================================

Name: fft_reorder_buf

Overview:
- Parametrised streaming reorder buffer placed directly after the FFT core.
- Converts the core's bit-reversed output stream into natural-order frames, or passes frames straight through in arrival order.
- Ping-pong buffered, so back-to-back frames stream with no gaps.
- Generalises the fixed 1024-point, 24-bit, always-valid stream: point count and width are parameters, and the block adds valid/SOF framing, per-frame mode selection and resynchronisation.

Parameters:
- DATA_W, 24: sample width (packed complex, re in upper half, im in lower half); opaque to this block.
- LOG2N, 10: log2 of frame length; N = 2**LOG2N; legal range 2..12.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is presented this cycle.
- in_data  input  DATA_W  input sample.
- in_sof  input  1  qualified by in_valid; marks sample 0 of a frame.
- rev_en  input  1  sampled with sample 0 of each frame. 1 = bit-reverse reorder, 0 = pass through in arrival order.
- out_valid  output  1  out_data is valid.
- out_data  output  DATA_W  output sample.
- out_sof  output  1  high with output index 0.
- out_last  output  1  high with output index N-1.

Behaviour:
- Reset (synchronous, active-high, single clock) clears the following on the first rising edge with reset=1:
  - write count, write bank, both bank-full flags, read state, read count;
  - out_valid, out_sof, out_last and out_data.
  - Reset overrides every other input.
  - Partial frames and frames queued or being read at reset are discarded. Outputs are 0 from the edge after reset is asserted.
  - After reset, the next accepted sample is frame index 0 even without in_sof.
- Write side:
  - A sample is accepted when in_valid=1.
  - in_valid=0 holds all write state; gaps of any length are allowed.
  - in_valid & in_sof forces this sample to index 0 of a new frame in the current write bank, discarding any partial frame. rev_en is latched for that bank.
  - Sample index w is written to bank address bitrev(w) when rev_en=1, and to address w when rev_en=0.
  - On acceptance of index N-1, the bank is marked full and the writer toggles bank; the write count wraps to 0.
  - in_sof on an index-0 sample is redundant and harmless.
- Read side (FSM IDLE / READ):
  - IDLE -> READ on the edge after any bank is full.
  - READ issues address r = 0..N-1, one per cycle, to the full bank.
  - The RAM read is registered, so out_valid rises 2 edges after the edge that accepted sample N-1.
  - On issuing r=N-1: the bank-full flag clears. If the other bank is full, read continues at r=0 of that bank on the next edge with no bubble; otherwise the FSM returns to IDLE.
  - out_sof and out_last are aligned with data for r=0 and r=N-1.
- Throughput and latency:
  - One sample per cycle each way.
  - With continuous input, the output is continuous.
  - Latency from first input to first output is N+1 cycles.
  - Overflow is impossible: a bank refill takes at least N cycles, which equals the read time. No backpressure port exists.
- Simultaneous events:
  - A write to bank X and a read of bank Y≠X in the same cycle is the normal case.
  - The writer never targets a bank that is still being read.
- out_data holds its last value while out_valid=0. Bench checks data only when valid.

Decomposition:
- Package fft_pkg holds:
  - function bitrev(value, LOG2N);
  - localparam N;
  - the read FSM state encoding (IDLE, READ).
- One sub-module, fft_dpram: simple dual-port RAM with synchronous write, registered read, depth 2N, width DATA_W. The bank select is the MSB of the address.
- fft_reorder_buf holds the counters, flags, FSM and output pipeline register.

Test Plan:
1. LOG2N=3, rev_en=1, in_sof on first sample, continuous in_data=0..7 -> out_data 0,4,2,6,1,5,3,7. out_valid asserted 2 edges after sample 7 is accepted; out_sof with 0, out_last with 7.
2. LOG2N=3, rev_en=0, in_data=0..7 -> out 0..7 in order, same latency and markers.
3. LOG2N=3, four back-to-back frames with rev_en toggling per frame (1,0,1,0) and data 0..31 -> out_valid continuous for 32 cycles. Each frame is reordered or passed according to its own latched rev_en.
4. LOG2N=3, in_valid pattern 1,0,0,1,… with random gaps, rev_en=1 -> output identical to scenario 1; output is a contiguous 8-cycle burst.
5. LOG2N=3: 5 samples, then in_sof with data 100..107 -> first 5 samples discarded; output is 100,104,102,106,101,105,103,107.
6. Default LOG2N=10, DATA_W=24, continuous 1024-sample frames: reset asserted one cycle mid-read -> out_valid=0 from the next edge, no stale samples. The following full frame is output bit-reverse-correct against the golden file.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer: default frame size,
// read-side FSM encoding and the index bit-reversal helper.
package fft_pkg;

    localparam int LOG2N_DEF = 10;
    localparam int LOG2N_MAX = 12;
    localparam int N         = 1 << LOG2N_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // Reverses the low log2n bits of value; bits at and above log2n come back as 0.
    function automatic logic [LOG2N_MAX-1:0] bitrev(input logic [LOG2N_MAX-1:0] value,
                                                    input int log2n);
        logic [LOG2N_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N_MAX; i++) begin
            if (i < log2n) begin
                r[log2n-1-i] = value[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM for the reorder buffer: synchronous write, registered read.
// The address MSB selects the ping-pong bank.
module fft_dpram #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array is deliberately not reset; the bank-full flags
    // decide what is valid, and a reset loop would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the output data register, so it is cleared
    // by reset and holds its value whenever no read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_reorder_buf.sv
// Streaming ping-pong reorder buffer: turns the FFT core's bit-reversed output
// into natural-order frames, or passes frames through, selectable per frame.
module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int LOG2N  = LOG2N_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              rev_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_last
);

    localparam int               NPTS     = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NPTS - 1);

    logic [LOG2N-1:0] wr_cnt;
    logic             wr_bank;
    logic [1:0]       bank_full;
    logic [1:0]       bank_rev;
    logic [LOG2N-1:0] wr_idx;
    logic [LOG2N-1:0] wr_offs;
    logic             wr_rev;
    logic             wr_done;
    logic [LOG2N:0]   wr_addr;

    rd_state_t        state;
    rd_state_t        state_next;
    logic             rd_bank;
    logic [LOG2N-1:0] rd_cnt;
    logic             rd_en;
    logic             frame_end;
    logic [LOG2N:0]   rd_addr;

    // An SOF sample always restarts the frame at index 0; rev_en is taken
    // live on index 0 and from the bank's latched copy for later samples.
    always_comb begin
        wr_idx  = in_sof ? '0 : wr_cnt;
        wr_rev  = (wr_idx == '0) ? rev_en : bank_rev[wr_bank];
        wr_offs = wr_rev ? LOG2N'(bitrev(LOG2N_MAX'(wr_idx), LOG2N)) : wr_idx;
        wr_addr = {wr_bank, wr_offs};
        wr_done = in_valid && (wr_idx == LAST_IDX);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            bank_rev <= '0;
        end else if (in_valid) begin
            if (wr_idx == '0) begin
                bank_rev[wr_bank] <= rev_en;
            end
            if (wr_done) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_idx + LOG2N'(1);
            end
        end
    end

    // Reader and writer never touch the same bank, so set and clear never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full <= '0;
        end else begin
            if (frame_end) begin
                bank_full[rd_bank] <= 1'b0;
            end
            if (wr_done) begin
                bank_full[wr_bank] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            state <= state_next;
            if (rd_en) begin
                rd_cnt <= rd_cnt + LOG2N'(1);
            end
            if (frame_end) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case can leave a latch behind.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bank_full[rd_bank]) begin
                    state_next = READ;
                end
            end
            READ: begin
                rd_en = 1'b1;
                if (rd_cnt == LAST_IDX) begin
                    frame_end = 1'b1;
                    if (!bank_full[~rd_bank]) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        rd_addr = {rd_bank, rd_cnt};
    end

    // Framing flags are delayed one cycle to line up with the registered RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= rd_en;
            out_sof   <= rd_en && (rd_cnt == '0);
            out_last  <= frame_end;
        end
    end

    fft_dpram #(
        .DATA_W(DATA_W),
        .ADDR_W(LOG2N + 1)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (in_valid),
        .wr_addr(wr_addr),
        .wr_data(in_data),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(out_data)
    );

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Scoreboard bench for fft_reorder_buf: an 8-point instance for the framing
// scenarios and a default 1024-point instance for the mid-read reset case.
module tb_fft_reorder_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        in_valid  [2];
    logic        in_sof    [2];
    logic        rev_en    [2];
    logic [23:0] in_data   [2];
    logic        out_valid [2];
    logic        out_sof   [2];
    logic        out_last  [2];
    logic [23:0] out_data  [2];

    fft_reorder_buf #(.DATA_W(24), .LOG2N(3)) dut_s (
        .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_sof(in_sof[0]), .rev_en(rev_en[0]), .out_valid(out_valid[0]),
        .out_data(out_data[0]), .out_sof(out_sof[0]), .out_last(out_last[0])
    );

    fft_reorder_buf dut_b (
        .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_sof(in_sof[1]), .rev_en(rev_en[1]), .out_valid(out_valid[1]),
        .out_data(out_data[1]), .out_sof(out_sof[1]), .out_last(out_last[1])
    );

    // Expected entries are {sof, last, data}.
    logic [25:0] exp_q [2][$];
    logic [23:0] cur_q [2][$];
    bit          cur_rev [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc;
    int sof_cyc  [2];
    int run_len  [2];
    int last_run [2];
    bit prev_valid [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int npts(input int i);
        return (i == 0) ? 8 : 1024;
    endfunction

    function automatic int lg(input int i);
        return (i == 0) ? 3 : 10;
    endfunction

    function automatic int tb_bitrev(input int v, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) r = (r << 1) | ((v >> b) & 1);
        return r;
    endfunction

    // Frame-level reference: collect accepted samples; a complete frame yields
    // output k = sample bitrev(k) when reversed, sample k otherwise.
    task automatic model_accept(input int i, input logic [23:0] d, input logic sof, input logic rev);
        int n = npts(i);
        if (sof) cur_q[i].delete();
        if (cur_q[i].size() == 0) cur_rev[i] = rev;
        cur_q[i].push_back(d);
        if (cur_q[i].size() == n) begin
            for (int k = 0; k < n; k++) begin
                int w = cur_rev[i] ? tb_bitrev(k, lg(i)) : k;
                exp_q[i].push_back({k == 0, k == n - 1, cur_q[i][w]});
            end
            cur_q[i].delete();
        end
    endtask

    task automatic send(input int i, input logic [23:0] d, input logic sof, input logic rev);
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        in_sof[i]   = sof;
        rev_en[i]   = rev;
        @(posedge clk);
        #1;
        model_accept(i, d, sof, rev);
        acc_cyc     = cyc;
        in_valid[i] = 1'b0;
        in_sof[i]   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int i, input string name);
        int t = 0;
        while (exp_q[i].size() != 0 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check({name, "_drained"}, exp_q[i].size(), 0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (out_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("out%0d_expected_any", i), 0, 1);
                end else begin
                    logic [25:0] e;
                    e = exp_q[i].pop_front();
                    check($sformatf("out%0d_sof_last_data", i),
                          {6'd0, out_sof[i], out_last[i], out_data[i]}, {6'd0, e});
                end
                if (out_sof[i]) sof_cyc[i] = cyc;
                else check($sformatf("out%0d_no_burst_gap", i), prev_valid[i], 1);
                run_len[i]++;
            end else begin
                if (run_len[i] != 0) last_run[i] = run_len[i];
                run_len[i] = 0;
            end
            prev_valid[i] = out_valid[i];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int first_acc;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; in_valid[i] = 1'b0; in_sof[i] = 1'b0;
            rev_en[i] = 1'b0; in_data[i] = '0;
            run_len[i] = 0; last_run[i] = 0; prev_valid[i] = 1'b0; sof_cyc[i] = 0;
        end
        idle(2);
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_outputs%0d", i),
                  {out_valid[i], out_sof[i], out_last[i], out_data[i]}, 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        idle(2);

        // S1: reversed frame, continuous input, latency and markers.
        for (int d = 0; d < 8; d++) begin
            send(0, 24'(d), d == 0, (d == 0) ? 1'b1 : 1'($urandom));
            if (d == 0) first_acc = acc_cyc;
        end
        wait_drain(0, "s1");
        check("s1_last_to_first_out", sof_cyc[0] - acc_cyc, 2);
        check("s1_first_in_to_first_out", sof_cyc[0] - first_acc, 9);
        check("s1_burst_len", last_run[0], 8);

        // S2: pass-through frame.
        for (int d = 0; d < 8; d++) send(0, 24'(d), d == 0, 1'b0);
        wait_drain(0, "s2");
        check("s2_last_to_first_out", sof_cyc[0] - acc_cyc, 2);

        // S3: four back-to-back frames, alternating mode.
        for (int d = 0; d < 32; d++) send(0, 24'(d), (d % 8) == 0, ((d / 8) % 2) == 0);
        wait_drain(0, "s3");
        check("s3_continuous_len", last_run[0], 32);

        // S4: reversed frame with random input gaps.
        for (int d = 0; d < 8; d++) begin
            send(0, 24'(d), d == 0, (d == 0) ? 1'b1 : 1'($urandom));
            idle($urandom_range(0, 3));
        end
        wait_drain(0, "s4");
        check("s4_burst_len", last_run[0], 8);

        // S5: partial frame abandoned by a new SOF.
        for (int d = 0; d < 5; d++) send(0, 24'(50 + d), d == 0, 1'b0);
        for (int d = 0; d < 8; d++) send(0, 24'(100 + d), d == 0, 1'b1);
        wait_drain(0, "s5");
        check("s5_burst_len", last_run[0], 8);

        // S6: 1024-point frames, reset during a read, then a clean frame.
        for (int d = 0; d < 1024; d++) send(1, 24'($urandom), d == 0, 1'b1);
        for (int d = 0; d < 500; d++) send(1, 24'($urandom), d == 0, 1'b0);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        exp_q[1].delete();
        cur_q[1].delete();
        rst[1] = 1'b0;
        check("s6_outputs_after_reset",
              {out_valid[1], out_sof[1], out_last[1], out_data[1]}, 0);
        idle(20);
        check("s6_quiet_after_reset", out_valid[1], 0);
        for (int d = 0; d < 1024; d++) send(1, 24'($urandom), 1'b0, (d == 0) ? 1'b1 : 1'($urandom));
        for (int d = 0; d < 1024; d++) send(1, 24'($urandom), 1'b0, 1'b0);
        wait_drain(1, "s6");
        check("s6_continuous_len", last_run[1], 2048);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
